mvd_can_mv_seq: RTL and testbench

- Sequential, parametrised successor to the spatial-neighbour MV address logic in rec_mc.
- On each start it latches one PU's geometry, then evaluates the five HEVC spatial candidates A0, A1, B0, B1, B2 in that order.
- Per candidate it emits an availability flag and a MV-buffer address, using a valid/ready handshake.
- Availability is generalised to any LCU/min-block ratio by a z-order (Morton) comparison. It adds the B2 candidate and a separate top-line/corner source.

---
 rtl/mvd_can_mv_seq_if.sv | 26 ++
 rtl/mvd_can_mv_seq.sv | 261 ++++++++++++++++++++++++++
 tb/tb_mvd_can_mv_seq.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mvd_can_mv_seq_if.sv
// rtl/mvd_can_mv_seq_if.sv - candidate stream interface of mvd_can_mv_seq (valid/ready, id, availability, address)
interface mvd_can_mv_seq_if #(
  parameter int AW = 10
);
  logic          cand_vld_o;
  logic          cand_rdy_i;
  logic [2:0]    cand_id_o;
  logic          cand_avail_o;
  logic [AW-1:0] cand_addr_o;

  modport master (
    output cand_vld_o,
    output cand_id_o,
    output cand_avail_o,
    output cand_addr_o,
    input  cand_rdy_i
  );

  modport slave (
    input  cand_vld_o,
    input  cand_id_o,
    input  cand_avail_o,
    input  cand_addr_o,
    output cand_rdy_i
  );
endinterface

// File: rtl/mvd_can_mv_seq.sv
// rtl/mvd_can_mv_seq.sv - sequential HEVC spatial MV candidate generator (A0,A1,B0,B1,B2)
// Latches one PU, classifies all five neighbours in one cycle, then streams them out.
module mvd_can_mv_seq #(
  parameter  int LCU_SIZE    = 64,
  parameter  int MIN_SIZE    = 8,
  parameter  int PIC_X_WIDTH = 8,
  parameter  int PIC_Y_WIDTH = 8,
  localparam int LW          = $clog2(LCU_SIZE),
  localparam int N           = LCU_SIZE / MIN_SIZE,
  localparam int G           = $clog2(N),
  localparam int AW          = 2 + 2 * (G + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [PIC_X_WIDTH-1:0] mb_x_total_i,
  input  logic [PIC_Y_WIDTH-1:0] mb_y_total_i,
  input  logic [PIC_X_WIDTH-1:0] mb_x_i,
  input  logic [PIC_Y_WIDTH-1:0] mb_y_i,
  input  logic [G-1:0]           ctu_x_res_i,
  input  logic [G-1:0]           ctu_y_res_i,
  input  logic [LW-1:0]          pos_x_i,
  input  logic [LW-1:0]          pos_y_i,
  input  logic [LW:0]            pu_width_i,
  input  logic [LW:0]            pu_height_i,
  output logic                   busy_o,
  output logic                   done_o,
  mvd_can_mv_seq_if.master       cand_if
);
  localparam int ML = $clog2(MIN_SIZE);
  localparam int CW = G + 2;

  typedef logic signed [CW-1:0] crd_t;
  typedef logic [G:0]           fld_t;
  typedef logic [AW-1:0]        adr_t;

  localparam crd_t ONE      = crd_t'(1);
  localparam crd_t NS       = crd_t'(N);
  localparam fld_t F_LAST   = fld_t'(N - 1);
  localparam fld_t F_CORNER = fld_t'(2 * N - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_EMIT, S_DONE} state_t;

  state_t state_q, state_d;

  logic [PIC_X_WIDTH-1:0] mbx_q, mbxt_q;
  logic [PIC_Y_WIDTH-1:0] mby_q, mbyt_q;
  logic [G-1:0]           resx_q, resy_q, px_q, py_q;
  logic [G:0]             pw_q, ph_q;
  logic                   latch;

  logic                   res_avail   [5];
  adr_t                   res_addr    [5];
  logic                   res_avail_q [5];
  adr_t                   res_addr_q  [5];

  logic       vld_q, vld_d, busy_q, busy_d, done_q, done_d, avail_q, avail_d;
  logic [2:0] id_q, id_d;
  adr_t       addr_q, addr_d;

  // Offsets are MIN_SIZE aligned, so the sub-grid bits carry no information.
  logic unused_lsbs;
  assign unused_lsbs = ^{pos_x_i[ML-1:0], pos_y_i[ML-1:0],
                         pu_width_i[ML-1:0], pu_height_i[ML-1:0]};

  function automatic logic [2*G-1:0] zidx(input logic [G-1:0] x, input logic [G-1:0] y);
    zidx = '0;
    for (int b = 0; b < G; b++) begin
      zidx[2*b]   = x[b];
      zidx[2*b+1] = y[b];
    end
  endfunction

  crd_t sx, sy, sw, sh, srx, sry;
  crd_t nx_c [5];
  crd_t ny_c [5];
  logic edge_x, edge_y, has_left, has_top, has_right, pu_out;

  assign sx        = crd_t'({2'b00, px_q});
  assign sy        = crd_t'({2'b00, py_q});
  assign sw        = crd_t'({1'b0, pw_q});
  assign sh        = crd_t'({1'b0, ph_q});
  assign srx       = crd_t'({2'b00, resx_q});
  assign sry       = crd_t'({2'b00, resy_q});
  assign edge_x    = (mbx_q == mbxt_q);
  assign edge_y    = (mby_q == mbyt_q);
  assign has_left  = (mbx_q != '0);
  assign has_top   = (mby_q != '0);
  assign has_right = (mbx_q < mbxt_q);
  assign pu_out    = (edge_x && (px_q > resx_q)) || (edge_y && (py_q > resy_q));

  always_comb begin
    nx_c[0] = sx - ONE;       ny_c[0] = sy + sh;
    nx_c[1] = sx - ONE;       ny_c[1] = sy + sh - ONE;
    nx_c[2] = sx + sw;        ny_c[2] = sy - ONE;
    nx_c[3] = sx + sw - ONE;  ny_c[3] = sy - ONE;
    nx_c[4] = sx - ONE;       ny_c[4] = sy - ONE;
  end

  always_comb begin : classify
    logic       av;
    logic [1:0] src;
    fld_t       fx, fy;
    crd_t       nx, ny;
    av  = 1'b0;
    src = 2'b00;
    fx  = '0;
    fy  = '0;
    nx  = '0;
    ny  = '0;
    for (int i = 0; i < 5; i++) begin
      nx  = nx_c[i];
      ny  = ny_c[i];
      av  = 1'b0;
      src = 2'b00;
      fx  = '0;
      fy  = '0;
      if (pu_out) begin
        av = 1'b0;
      end else if ((edge_x && (nx > srx)) || (edge_y && (ny > sry))) begin
        av = 1'b0;
      end else if (ny[CW-1]) begin
        // Top line buffer; x = 2N-1 addresses the corner slot of the upper-left LCU.
        src = 2'b11;
        fy  = F_LAST;
        if (nx[CW-1]) begin
          av = has_top && has_left;
          fx = F_CORNER;
        end else if (nx == NS) begin
          av = has_top && has_right;
          fx = nx[G:0];
        end else begin
          av = has_top;
          fx = nx[G:0];
        end
      end else if (nx[CW-1]) begin
        src = 2'b01;
        av  = has_left && (ny < NS);
        fx  = F_LAST;
        fy  = ny[G:0];
      end else if ((nx < NS) && (ny < NS)) begin
        src = 2'b10;
        av  = zidx(nx[G-1:0], ny[G-1:0]) < zidx(px_q, py_q);
        fx  = nx[G:0];
        fy  = ny[G:0];
      end
      res_avail[i] = av;
      res_addr[i]  = av ? {src, fy, fx} : '0;
    end
  end

  always_comb begin
    state_d = state_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    id_d    = id_q;
    avail_d = avail_q;
    addr_d  = addr_q;
    latch   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        vld_d   = 1'b0;
        busy_d  = 1'b0;
        id_d    = '0;
        avail_d = 1'b0;
        addr_d  = '0;
        if (start_i) begin
          latch   = 1'b1;
          busy_d  = 1'b1;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        state_d = S_EMIT;
        vld_d   = 1'b1;
        id_d    = '0;
        avail_d = res_avail[0];
        addr_d  = res_addr[0];
      end
      S_EMIT: begin
        if (vld_q && cand_if.cand_rdy_i) begin
          if (id_q == 3'd4) begin
            state_d = S_DONE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            id_d    = '0;
            avail_d = 1'b0;
            addr_d  = '0;
          end else begin
            id_d    = id_q + 3'd1;
            avail_d = res_avail_q[id_q + 3'd1];
            addr_d  = res_addr_q[id_q + 3'd1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      id_q    <= '0;
      avail_q <= 1'b0;
      addr_q  <= '0;
      mbx_q   <= '0;
      mbxt_q  <= '0;
      mby_q   <= '0;
      mbyt_q  <= '0;
      resx_q  <= '0;
      resy_q  <= '0;
      px_q    <= '0;
      py_q    <= '0;
      pw_q    <= '0;
      ph_q    <= '0;
      for (int i = 0; i < 5; i++) begin
        res_avail_q[i] <= 1'b0;
        res_addr_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      id_q    <= id_d;
      avail_q <= avail_d;
      addr_q  <= addr_d;
      if (latch) begin
        mbx_q  <= mb_x_i;
        mbxt_q <= mb_x_total_i;
        mby_q  <= mb_y_i;
        mbyt_q <= mb_y_total_i;
        resx_q <= ctu_x_res_i;
        resy_q <= ctu_y_res_i;
        px_q   <= pos_x_i[LW-1:ML];
        py_q   <= pos_y_i[LW-1:ML];
        pw_q   <= pu_width_i[LW:ML];
        ph_q   <= pu_height_i[LW:ML];
      end
      if (state_q == S_CALC) begin
        for (int i = 0; i < 5; i++) begin
          res_avail_q[i] <= res_avail[i];
          res_addr_q[i]  <= res_addr[i];
        end
      end
    end
  end

  assign busy_o               = busy_q;
  assign done_o               = done_q;
  assign cand_if.cand_vld_o   = vld_q;
  assign cand_if.cand_id_o    = id_q;
  assign cand_if.cand_avail_o = avail_q;
  assign cand_if.cand_addr_o  = addr_q;
endmodule

// File: tb/tb_mvd_can_mv_seq.sv
// tb/tb_mvd_can_mv_seq.sv - self-checking bench for mvd_can_mv_seq (vector table + random vs reference model)
`timescale 1ns/1ps
module tb_mvd_can_mv_seq;
  localparam int LCU = 64;
  localparam int MIN = 8;
  localparam int PXW = 8;
  localparam int PYW = 8;
  localparam int LW  = $clog2(LCU);
  localparam int N   = LCU / MIN;
  localparam int G   = $clog2(N);
  localparam int AW  = 2 + 2 * (G + 1);

  typedef struct packed {
    int mbx, mby, mbxt, mbyt, resx, resy, posx, posy, w, h;
  } pu_t;

  typedef struct packed {
    pu_t                 p;
    logic [4:0]          av;
    logic [4:0][AW-1:0]  ad;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [PXW-1:0] mbxt = '0, mbx = '0;
  logic [PYW-1:0] mbyt = '0, mby = '0;
  logic [G-1:0]   resx = '0, resy = '0;
  logic [LW-1:0]  posx = '0, posy = '0;
  logic [LW:0]    puw = '0, puh = '0;
  logic           busy, done;

  int n_chk  = 0;
  int n_fail = 0;

  mvd_can_mv_seq_if #(.AW(AW)) cif ();

  mvd_can_mv_seq #(
    .LCU_SIZE(LCU), .MIN_SIZE(MIN), .PIC_X_WIDTH(PXW), .PIC_Y_WIDTH(PYW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start),
    .mb_x_total_i(mbxt), .mb_y_total_i(mbyt), .mb_x_i(mbx), .mb_y_i(mby),
    .ctu_x_res_i(resx), .ctu_y_res_i(resy), .pos_x_i(posx), .pos_y_i(posy),
    .pu_width_i(puw), .pu_height_i(puh),
    .busy_o(busy), .done_o(done), .cand_if(cif)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] mk(input int src, input int y, input int x);
    return AW'((src << (2 * (G + 1))) | (y << (G + 1)) | x);
  endfunction

  function automatic pu_t mkp(input int a, b, c, d, e, f, g, h, i, j);
    pu_t p;
    p.mbx = a; p.mby = b; p.mbxt = c; p.mbyt = d; p.resx = e;
    p.resy = f; p.posx = g; p.posy = h; p.w = i; p.h = j;
    return p;
  endfunction

  function automatic int zz(input int x, input int y);
    int r = 0;
    for (int b = 0; b < G; b++)
      r += (((x >> b) & 1) << (2 * b)) + (((y >> b) & 1) << (2 * b + 1));
    return r;
  endfunction

  // Reference: straight from the neighbour rules, on plain integers.
  function automatic vec_t model(input pu_t p);
    vec_t v;
    int px, py, pw, ph, x, y, src, fx, fy;
    int nx [5];
    int ny [5];
    bit pu_out, a;
    v.p = p; v.av = '0; v.ad = '0;
    px = p.posx / MIN; py = p.posy / MIN; pw = p.w / MIN; ph = p.h / MIN;
    nx = '{px - 1, px - 1, px + pw, px + pw - 1, px - 1};
    ny = '{py + ph, py + ph - 1, py - 1, py - 1, py - 1};
    pu_out = (p.mbx == p.mbxt && px > p.resx) || (p.mby == p.mbyt && py > p.resy);
    for (int i = 0; i < 5; i++) begin
      x = nx[i]; y = ny[i]; a = 0; src = 0; fx = 0; fy = 0;
      if (pu_out) a = 0;
      else if ((p.mbx == p.mbxt && x > p.resx) || (p.mby == p.mbyt && y > p.resy)) a = 0;
      else if (y < 0) begin
        src = 3; fy = N - 1; fx = (x < 0) ? 2 * N - 1 : x;
        a = (p.mby > 0) && (x >= 0 || p.mbx > 0) && (x != N || p.mbx < p.mbxt);
      end else if (x < 0) begin
        src = 1; fx = N - 1; fy = y; a = (p.mbx > 0) && (y < N);
      end else if (x < N && y < N) begin
        src = 2; fx = x; fy = y; a = zz(x, y) < zz(px, py);
      end
      v.av[i] = a;
      v.ad[i] = a ? mk(src, fy, fx) : '0;
    end
    return v;
  endfunction

  function automatic pu_t rand_pu();
    pu_t p;
    p.mbxt = $urandom_range(0, 4); p.mbx = $urandom_range(0, p.mbxt);
    p.mbyt = $urandom_range(0, 4); p.mby = $urandom_range(0, p.mbyt);
    p.resx = $urandom_range(0, N - 1); p.resy = $urandom_range(0, N - 1);
    p.posx = MIN * $urandom_range(0, N - 1); p.posy = MIN * $urandom_range(0, N - 1);
    p.w = MIN * $urandom_range(1, N - p.posx / MIN);
    p.h = MIN * $urandom_range(1, N - p.posy / MIN);
    return p;
  endfunction

  task automatic drive(input pu_t p);
    mbx = p.mbx[PXW-1:0]; mby = p.mby[PYW-1:0];
    mbxt = p.mbxt[PXW-1:0]; mbyt = p.mbyt[PYW-1:0];
    resx = p.resx[G-1:0]; resy = p.resy[G-1:0];
    posx = p.posx[LW-1:0]; posy = p.posy[LW-1:0];
    puw = p.w[LW:0]; puh = p.h[LW:0];
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_vld"}, cif.cand_vld_o, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_id"}, cif.cand_id_o, 0);
    chk({tag, "_avail"}, cif.cand_avail_o, 0);
    chk({tag, "_addr"}, cif.cand_addr_o, 0);
  endtask

  // Called at a negedge; returns at the negedge where done_o is expected high.
  // mode 0: ready tied high, 1: random ready, 2: ready held low for 3 cycles at id 1.
  task automatic run_pu(input vec_t v, input int mode, input bit poke);
    int stall;
    bit r;
    drive(v.p);
    start = 1'b1;
    cif.cand_rdy_i = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("calc_busy", busy, 1);
    chk("calc_vld", cif.cand_vld_o, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      stall = 0;
      do begin
        chk("emit_vld", cif.cand_vld_o, 1);
        chk("emit_busy", busy, 1);
        chk("emit_done", done, 0);
        chk("emit_id", cif.cand_id_o, k);
        chk("emit_avail", cif.cand_avail_o, v.av[k]);
        chk("emit_addr", cif.cand_addr_o, v.ad[k]);
        case (mode)
          0:       r = 1'b1;
          1:       r = (stall >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
          default: r = !(k == 1 && stall < 3);
        endcase
        cif.cand_rdy_i = r;
        if (poke && k == 2 && stall == 0) begin
          start = 1'b1;
          drive(rand_pu());
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        stall++;
      end while (!r);
    end
    cif.cand_rdy_i = 1'b0;
    start = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_vld", cif.cand_vld_o, 0);
    chk("done_busy", busy, 0);
  endtask

  vec_t vt [10];
  vec_t rv;

  initial begin
    cif.cand_rdy_i = 1'b0;
    vt[0].p = mkp(0, 0, 4, 4, 7, 7, 0, 0, 64, 64);  vt[0].av = 5'b00000;
    vt[0].ad = '0;
    vt[1].p = mkp(2, 1, 4, 3, 7, 7, 0, 0, 16, 16);  vt[1].av = 5'b11111;
    vt[1].ad = {mk(3, 7, 15), mk(3, 7, 1), mk(3, 7, 2), mk(1, 1, 7), mk(1, 2, 7)};
    vt[2].p = mkp(2, 1, 4, 3, 7, 7, 16, 0, 16, 16); vt[2].av = 5'b11110;
    vt[2].ad = {mk(3, 7, 1), mk(3, 7, 3), mk(3, 7, 4), mk(2, 1, 1), AW'(0)};
    vt[3].p = mkp(2, 1, 4, 3, 7, 7, 0, 32, 32, 32); vt[3].av = 5'b11110;
    vt[3].ad = {mk(1, 3, 7), mk(2, 3, 3), mk(2, 3, 4), mk(1, 7, 7), AW'(0)};
    vt[4].p = mkp(3, 1, 3, 5, 3, 7, 16, 0, 16, 16); vt[4].av = 5'b11010;
    vt[4].ad = {mk(3, 7, 1), mk(3, 7, 3), AW'(0), mk(2, 1, 1), AW'(0)};
    vt[5].p = mkp(3, 1, 3, 5, 1, 7, 16, 0, 16, 16); vt[5].av = 5'b00000;
    vt[5].ad = '0;
    vt[6].p = mkp(2, 1, 4, 3, 7, 7, 48, 0, 16, 16); vt[6].av = 5'b11110;
    vt[6].ad = {mk(3, 7, 5), mk(3, 7, 7), mk(3, 7, 8), mk(2, 1, 5), AW'(0)};
    vt[7].p = mkp(2, 1, 2, 3, 7, 7, 48, 0, 16, 16); vt[7].av = 5'b11010;
    vt[7].ad = {mk(3, 7, 5), mk(3, 7, 7), AW'(0), mk(2, 1, 5), AW'(0)};
    vt[8].p = mkp(2, 0, 4, 3, 7, 7, 0, 0, 16, 16);  vt[8].av = 5'b00011;
    vt[8].ad = {AW'(0), AW'(0), AW'(0), mk(1, 1, 7), mk(1, 2, 7)};
    vt[9].p = mkp(1, 2, 4, 2, 7, 1, 0, 0, 16, 16);  vt[9].av = 5'b11110;
    vt[9].ad = {mk(3, 7, 15), mk(3, 7, 1), mk(3, 7, 2), mk(1, 1, 7), AW'(0)};

    repeat (2) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_idle("post_reset");

    // vector 1 stalls at id 1, vector 2 pokes start mid-stream, vector 3 chains from DONE
    for (int i = 0; i < 10; i++) begin
      run_pu(vt[i], (i == 1) ? 2 : 0, i == 2);
      if (i != 2) begin
        @(negedge clk);
        chk_idle("after_done");
      end
    end

    // reset asserted mid-stream clears outputs at once and never pulses done
    drive(vt[1].p);
    start = 1'b1;
    cif.cand_rdy_i = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_vld", cif.cand_vld_o, 1);
    cif.cand_rdy_i = 1'b1;
    @(negedge clk);
    chk("pre_rst_id", cif.cand_id_o, 1);
    rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    cif.cand_rdy_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk_idle("rst_idle");
    end

    for (int i = 0; i < 40; i++) begin
      rv = model(rand_pu());
      run_pu(rv, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) != 0) begin
        @(negedge clk);
        chk_idle("rand_idle");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
